// File: rtl/ls_fifo_oc.sv
// ls_fifo_oc: synchronous FIFO whose head word is popped into a holding
// register that drives a shared tri-state bus while OC_b is low.
// Occupancy is tracked in a separate counter. Sticky flags record
// dropped pushes (ovf) and dropped pops (udf).
module ls_fifo_oc #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic [WIDTH-1:0]           D,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic                       clr,
    input  logic                       OC_b,
    output wire  [WIDTH-1:0]           Q,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic                       udf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] q_hold_q, q_hold_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic push_ok;
    logic pop_ok;

    // Flags are decoded from the counter so they can never disagree with it.
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

    // A full queue still accepts a push when a pop frees the head slot in the
    // same cycle. An empty queue never pops, so there is no write-through.
    assign push_ok = wr_en && (!full || rd_en);
    assign pop_ok  = rd_en && !empty;

    // Bus drive depends only on OC_b; queue state keeps moving while tri-stated.
    assign Q = OC_b ? {WIDTH{1'bz}} : q_hold_q;

    // Next-state computation for pointers, occupancy, holding register and flags.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves a _d
        // unassigned and no latch is inferred.
        wp_d     = wp_q;
        rp_d     = rp_q;
        count_d  = count_q;
        q_hold_d = q_hold_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (clr) begin
            // Flush wins over push and pop. q_hold deliberately keeps the bus value.
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (push_ok) begin
                wp_d = wp_q + 1'b1;
            end else if (wr_en) begin
                ovf_d = 1'b1;
            end

            if (pop_ok) begin
                rp_d     = rp_q + 1'b1;
                q_hold_d = mem_q[rp_q];
            end else if (rd_en) begin
                udf_d = 1'b1;
            end

            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            q_hold_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            count_q  <= count_d;
            q_hold_q <= q_hold_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array write port.
    // NOTE: the data array has no reset. Its contents are unreadable until
    // written, and this keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            mem_q[wp_q] <= D;
        end
    end

endmodule

// File: tb/tb_ls_fifo_oc.sv
// tb_ls_fifo_oc: directed and randomized stimulus. A queue-based reference
// model predicts the outputs, and every cycle's outputs are compared against it.
module tb_ls_fifo_oc;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_b;
    logic [WIDTH-1:0] d;
    logic             wr_en, rd_en, clr, oc_b;
    wire  [WIDTH-1:0] q;
    logic             empty, full, ovf, udf;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    // Reference model: queue contents, output holding value, sticky flags.
    logic [WIDTH-1:0] mdl_fifo [$];
    logic [WIDTH-1:0] mdl_hold;
    bit               mdl_ovf, mdl_udf;

    ls_fifo_oc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .D     (d),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .clr   (clr),
        .OC_b  (oc_b),
        .Q     (q),
        .empty (empty),
        .full  (full),
        .count (count),
        .ovf   (ovf),
        .udf   (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic check_all(input string tag);
        logic [31:0] exp_q;
        logic [31:0] obs_q;
        exp_q = '0;
        obs_q = '0;
        exp_q[WIDTH-1:0] = oc_b ? {WIDTH{1'bz}} : mdl_hold;
        obs_q[WIDTH-1:0] = q;
        check({tag, "/count"}, 32'(count), 32'(mdl_fifo.size()));
        check({tag, "/empty"}, 32'(empty), 32'(mdl_fifo.size() == 0));
        check({tag, "/full"},  32'(full),  32'(mdl_fifo.size() == DEPTH));
        check({tag, "/ovf"},   32'(ovf),   32'(mdl_ovf));
        check({tag, "/udf"},   32'(udf),   32'(mdl_udf));
        check({tag, "/q"},     obs_q,      exp_q);
    endtask

    // Drive one cycle, advance the model across the edge, then check outputs.
    task automatic step(input string tag, input bit w, input bit r, input bit c,
                        input logic [WIDTH-1:0] din);
        bit do_pop, do_push;
        wr_en = w;
        rd_en = r;
        clr   = c;
        d     = din;
        @(posedge clk);
        if (c) begin
            mdl_fifo.delete();
            mdl_ovf = 1'b0;
            mdl_udf = 1'b0;
        end else begin
            do_pop  = r && (mdl_fifo.size() > 0);
            do_push = w && ((mdl_fifo.size() < DEPTH) || r);
            if (do_pop) mdl_hold = mdl_fifo.pop_front();
            else if (r) mdl_udf = 1'b1;
            if (do_push) mdl_fifo.push_back(din);
            else if (w) mdl_ovf = 1'b1;
        end
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        mdl_fifo.delete();
        mdl_hold = '0;
        mdl_ovf  = 1'b0;
        mdl_udf  = 1'b0;
    endtask

    initial begin
        rst_b = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
        oc_b  = 1'b0;
        d     = '0;
        model_reset();

        // Power-on reset, asserted between clock edges.
        #2 rst_b = 1'b0;
        #1 check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;

        // Fill with 0x00..0x0F, then drain in order.
        for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, 0, WIDTH'(i));
        check("fill_full", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 0, 1, 0, '0);
            check("drain_val", 32'(q), 32'(i));
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Overflow when full, then push+pop at full.
        for (int i = 0; i < DEPTH; i++) step("refill", 1, 0, 0, WIDTH'(i));
        step("ovf_push", 1, 0, 0, 8'hAA);
        check("ovf_set", 32'(ovf), 32'd1);
        step("full_pushpop", 1, 1, 0, 8'hBB);
        check("full_pushpop_q", 32'(q), 32'h00);
        check("full_pushpop_cnt", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) step("drain2", 0, 1, 0, '0);
        check("last_is_bb", 32'(q), 32'hBB);

        // Underflow with a simultaneous push into an empty queue.
        step("clr_flags", 0, 0, 1, '0);
        step("udf_push", 1, 1, 0, 8'h55);
        check("udf_set", 32'(udf), 32'd1);
        check("udf_q_kept", 32'(q), 32'hBB);
        step("udf_pop", 0, 1, 0, '0);
        check("udf_pop_q", 32'(q), 32'h55);

        // Interleaved traffic that carries both pointers across the wrap.
        for (int i = 0; i < 40; i++) step("interleave", 1, (i >= 3), 0, WIDTH'($urandom));

        // clr wins over a simultaneous push and pop, and the bus value is kept.
        step("pre_clr_ovf", 1, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) step("top_up", 1, 0, 0, WIDTH'($urandom));
        step("clr_all", 1, 1, 1, 8'h77);
        check("clr_count", 32'(count), 32'd0);

        // Output control independence: pop while tri-stated, then enable.
        step("oc_push", 1, 0, 0, 8'h3C);
        oc_b = 1'b1;
        step("oc_pop_z", 0, 1, 0, '0);
        oc_b = 1'b0;
        #1 check("oc_enable_q", 32'(q), 32'h3C);

        // Randomized traffic with occasional flushes and output toggling.
        for (int i = 0; i < 400; i++) begin
            oc_b = ($urandom_range(0, 3) == 0);
            step("random", ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 49) == 0), WIDTH'($urandom));
        end

        // Asynchronous reset with data queued and the bus enabled.
        oc_b = 1'b0;
        for (int i = 0; i < 5; i++) step("pre_rst", 1, (i == 4), 0, WIDTH'(8'hC0 + i));
        #2 rst_b = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        oc_b = 1'b1;
        #1 check_all("async_rst_z");
        @(negedge clk);
        rst_b = 1'b1;
        oc_b  = 1'b0;
        step("post_rst", 1, 0, 0, 8'h99);
        step("post_rst_pop", 0, 1, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
